// File: rtl/ins_parser_pkg.sv
// ins_parser_pkg: shared widths, RV32I opcode constants, format enum,
// decoded-field payload and the opcode -> format lookup.
`timescale 1ns/1ps
package ins_parser_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned FMT_W = 3;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OP_FENCE  = 7'h0F;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'h73;

    typedef enum logic [FMT_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Registered decode payload.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F7_W-1:0]  funct7;
        fmt_e             fmt;
        logic [XLEN-1:0]  imm;
        logic             illegal;
    } fields_t;

    // Opcode -> format; anything unlisted (including bits[1:0] != 2'b11) is illegal.
    function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] op);
        fmt_e f;
        f = FMT_ILL;
        case (op)
            OP_OP:                                             f = FMT_R;
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM:     f = FMT_I;
            OP_STORE:                                          f = FMT_S;
            OP_BRANCH:                                         f = FMT_B;
            OP_LUI, OP_AUIPC:                                  f = FMT_U;
            OP_JAL:                                            f = FMT_J;
            default:                                           f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ins_parser_imm_gen.sv
// ins_parser_imm_gen: combinational RV32I immediate extraction.
// Ports:
//   instruction  instruction bits [31:7] (opcode bits are not needed, fmt encodes them)
//   fmt          decoded format
//   imm_c        sign-extended immediate, 0 for R and ILL
`timescale 1ns/1ps
module ins_parser_imm_gen
    import ins_parser_pkg::*;
(
    input  logic [XLEN-1:7] instruction,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm_c
);

    logic sgn;
    assign sgn = instruction[31];

    // Bit-scatter per format; sign bit replicated from instruction[31].
    always_comb begin
        imm_c = '0;
        case (fmt)
            FMT_I: imm_c = {{20{sgn}}, instruction[31:20]};
            FMT_S: imm_c = {{20{sgn}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm_c = {{19{sgn}}, sgn, instruction[7], instruction[30:25],
                            instruction[11:8], 1'b0};
            FMT_U: imm_c = {instruction[31:12], 12'b0};
            FMT_J: imm_c = {{11{sgn}}, sgn, instruction[19:12], instruction[20],
                            instruction[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/ins_parser.sv
// ins_parser: single-cycle-latency RV32I instruction field decoder.
// Optional feature macro: INS_PARSER_IMM_EN (immediate generator; imm is 0 without it).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid            instruction valid this cycle
//   instruction         RV32I instruction word
//   out_valid           in_valid delayed one cycle
//   opcode/rd/funct3/rs1/rs2/funct7  raw field slices (loaded on in_valid)
//   fmt                 format code R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   imm                 sign-extended immediate
//   illegal             opcode not recognised
`timescale 1ns/1ps
module ins_parser
    import ins_parser_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] instruction,
    output logic              out_valid,
    output logic [6:0]        opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [6:0]        funct7,
    output logic [2:0]        fmt,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    fmt_e              fmt_c;
    logic [DATA_W-1:0] imm_c;
    fields_t           nxt_c;
    fields_t           cur;

    assign fmt_c = decode_fmt(instruction[6:0]);

`ifdef INS_PARSER_IMM_EN
    ins_parser_imm_gen u_imm_gen (
        .instruction (instruction[DATA_W-1:7]),
        .fmt         (fmt_c),
        .imm_c       (imm_c)
    );
`else
    assign imm_c = '0;
`endif

    // Next payload: raw slices regardless of format.
    always_comb begin
        nxt_c         = '0;
        nxt_c.opcode  = instruction[6:0];
        nxt_c.rd      = instruction[11:7];
        nxt_c.funct3  = instruction[14:12];
        nxt_c.rs1     = instruction[19:15];
        nxt_c.rs2     = instruction[24:20];
        nxt_c.funct7  = instruction[31:25];
        nxt_c.fmt     = fmt_c;
        nxt_c.imm     = imm_c;
        nxt_c.illegal = (fmt_c == FMT_ILL);
    end

    // Valid follows in_valid; payload loads only on in_valid and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            cur         <= '0;
            cur.fmt     <= FMT_R;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                cur <= nxt_c;
            end
        end
    end

    assign opcode  = cur.opcode;
    assign rd      = cur.rd;
    assign funct3  = cur.funct3;
    assign rs1     = cur.rs1;
    assign rs2     = cur.rs2;
    assign funct7  = cur.funct7;
    assign fmt     = 3'(cur.fmt);
    assign imm     = cur.imm;
    assign illegal = cur.illegal;

endmodule

// File: tb/tb_ins_parser.sv
`timescale 1ns/1ps
module tb_ins_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        illegal;

    ins_parser #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .fmt         (fmt),
        .imm         (imm),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [67:0] f;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [67:0] last_f;
    logic [67:0] dut_f;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [6:0] ops  [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    int         fmts [11] = '{0, 1, 1, 1, 1, 1, 2, 3, 4, 4, 5};

    assign dut_f = {opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [67:0] act, logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [67:0] pack(logic [6:0] op, logic [4:0] d, logic [2:0] f3,
                                         logic [4:0] s1, logic [4:0] s2, logic [6:0] f7,
                                         logic [2:0] fm, logic [31:0] im, logic il);
        return {op, d, f3, s1, s2, f7, fm, im, il};
    endfunction

    // Immediate as the build presents it (constant 0 when the generator is absent).
    function automatic logic [31:0] bimm(logic [31:0] v);
`ifdef INS_PARSER_IMM_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    // Reference decode from the instruction-set rules.
    function automatic logic [67:0] model(logic [31:0] ins);
        logic signed [31:0] s;
        logic [31:0] im;
        int fm;
        s  = ins;
        fm = 7;
        im = 0;
        for (int i = 0; i < 11; i++) if (ins[6:0] == ops[i]) fm = fmts[i];
        case (fm)
            1: im = 32'(s >>> 20);
            2: im = (32'(s >>> 25) << 5) | ins[11:7];
            3: im = (32'(s >>> 31) << 12) | (ins[7] << 11) | (ins[30:25] << 5) | (ins[11:8] << 1);
            4: im = ins & 32'hFFFF_F000;
            5: im = (32'(s >>> 31) << 20) | (ins[19:12] << 12) | (ins[20] << 11) | (ins[30:21] << 1);
            default: im = 0;
        endcase
        return pack(ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25],
                    3'(fm), bimm(im), fm == 7);
    endfunction

    task automatic issue(logic [31:0] ins, logic [67:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        instruction = ins;
        e.f   = exp;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'b0;
            instruction = $urandom;
        end
    endtask

    // Mid-stream reset: outputs must clear before any clock edge.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        last_f = '0;
        #1;
        chk("async_reset_clear", {out_valid, dut_f}, '0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pops on out_valid, otherwise checks that fields hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {out_valid, dut_f}, '0);
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 68'(out_valid), 68'(0));
            end else begin
                mon_e = sb_q.pop_front();
                chk("fields", dut_f, mon_e.f);
                chk("latency_cycle", 68'(cyc), 68'(mon_e.cyc));
                last_f = mon_e.f;
            end
        end else begin
            chk("hold_fields", dut_f, last_f);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        last_f      = '0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Directed scenarios with hand-derived expectations.
        issue(32'h002081B3, pack(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 3'd0, 32'h0, 1'b0));
        issue(32'hFFF00293, pack(7'h13, 5'd5, 3'd0, 5'd0, 5'h1F, 7'h7F, 3'd1, bimm(32'hFFFF_FFFF), 1'b0));
        issue(32'h0020A423, pack(7'h23, 5'd8, 3'd2, 5'd1, 5'd2, 7'h00, 3'd2, bimm(32'h0000_0008), 1'b0));
        issue(32'hFE000EE3, pack(7'h63, 5'd29, 3'd0, 5'd0, 5'd0, 7'h7F, 3'd3, bimm(32'hFFFF_FFFC), 1'b0));
        issue(32'h123450B7, pack(7'h37, 5'd1, 3'd5, 5'd8, 5'd3, 7'h09, 3'd4, bimm(32'h1234_5000), 1'b0));
        issue(32'h00000000, pack(7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 3'd7, 32'h0, 1'b1));
        idle(3);

        // Reset between back-to-back instructions, then resume.
        issue(32'h00C58533, model(32'h00C58533));
        pulse_reset();
        idle(2);
        issue(32'h0080006F, model(32'h0080006F));
        idle(1);

        // Randomized traffic, biased toward legal opcodes.
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 3) != 0) issue(r, model(r));
            else idle(1);
            if (n == 200) begin
                pulse_reset();
                idle(1);
            end
        end
        idle(1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 68'(sb_q.size()), 68'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
